media_movil: RTL

//   Moving-average stage directly upstream of the comparator. Accepts one per-window

---
 rtl/media_movil_if.sv | 22 ++
 rtl/media_movil.sv | 76 +++++++
 2 files changed

// File: rtl/media_movil_if.sv
// Sample stream into the moving-average stage and the (actual, media) pair out.
// The master side drives samples; the slave side is the averaging stage.
interface media_movil_if #(
   parameter int W = 5
);
   logic [W-1:0] DataIn;
   logic         ValidIn;
   logic [W-1:0] DataOutActual;
   logic [W-1:0] DataOutMedia;
   logic         ValidOut;
   logic         Primed;

   modport master (
      output DataIn, ValidIn,
      input  DataOutActual, DataOutMedia, ValidOut, Primed
   );

   modport slave (
      input  DataIn, ValidIn,
      output DataOutActual, DataOutMedia, ValidOut, Primed
   );
endinterface

// File: rtl/media_movil.sv
// Moving average over the last DEPTH window counts, with a running sum.
// Emits the current sample and the floor average as a registered pair.
module media_movil #(
   parameter int SAMPLES = 2,
   parameter int OSF     = 8,
   parameter int DEPTH   = 4
) (
   input logic          CLK,
   input logic          RST,
   media_movil_if.slave bus
);
   localparam int W  = $clog2(SAMPLES * OSF) + 1;
   localparam int PW = $clog2(DEPTH);
   localparam int SW = W + PW;
   localparam int FW = $clog2(DEPTH + 1);

   logic [W-1:0]  buf_q [DEPTH];
   logic [PW-1:0] ptr_q, ptr_d;
   logic [SW-1:0] sum_q, sum_d;
   logic [FW-1:0] fill_q, fill_d;
   logic [W-1:0]  act_q, act_d;
   logic [W-1:0]  med_q, med_d;
   logic          vld_q, vld_d;
   logic          prim_q, prim_d;

   always_comb begin
      sum_d  = sum_q;
      ptr_d  = ptr_q;
      fill_d = fill_q;
      act_d  = act_q;
      med_d  = med_q;
      vld_d  = 1'b0;
      prim_d = prim_q;
      if (bus.ValidIn) begin
         // Oldest entry leaves the sum as the new one enters.
         sum_d  = sum_q + SW'(bus.DataIn) - SW'(buf_q[ptr_q]);
         ptr_d  = ptr_q + PW'(1);
         fill_d = (fill_q == FW'(DEPTH)) ? fill_q : fill_q + FW'(1);
         act_d  = bus.DataIn;
         med_d  = W'(sum_d >> PW);
         vld_d  = 1'b1;
         prim_d = (fill_d == FW'(DEPTH));
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            buf_q[i] <= '0;
         end
         ptr_q  <= '0;
         sum_q  <= '0;
         fill_q <= '0;
         act_q  <= '0;
         med_q  <= '0;
         vld_q  <= 1'b0;
         prim_q <= 1'b0;
      end else begin
         if (bus.ValidIn) begin
            buf_q[ptr_q] <= bus.DataIn;
         end
         ptr_q  <= ptr_d;
         sum_q  <= sum_d;
         fill_q <= fill_d;
         act_q  <= act_d;
         med_q  <= med_d;
         vld_q  <= vld_d;
         prim_q <= prim_d;
      end
   end

   assign bus.DataOutActual = act_q;
   assign bus.DataOutMedia  = med_q;
   assign bus.ValidOut      = vld_q;
   assign bus.Primed        = prim_q;
endmodule
